// File: rtl/gf13_inv_if.sv
// Handshake bundle for the GF(2^13) inverter: operand in, result/zero flag out, busy status.
interface gf13_inv_if #(parameter int M = 13);
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] a_in;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] inv_out;
  logic         zero_err;
  logic         busy;

  modport master (
    output in_valid, a_in, out_ready,
    input  in_ready, out_valid, inv_out, zero_err, busy
  );

  modport slave (
    input  in_valid, a_in, out_ready,
    output in_ready, out_valid, inv_out, zero_err, busy
  );
endinterface

// File: rtl/gf13_inverter.sv
// GF(2^13) PB inverter, a^-1 = a^(2^13-2) via 12 square+multiply rounds.
// Define GF13_INV_PARALLEL_MUL_EN for a single-cycle combinational multiply step.
module gf13_inverter #(
  parameter int           M    = 13,
  parameter logic [M-1:0] POLY = 13'h001B
) (
  input  logic       clk,
  input  logic       rst,
  gf13_inv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

  // Multiply by x, folding x^13 back in as POLY.
  function automatic logic [M-1:0] xtime(input logic [M-1:0] v);
    return {v[M-2:0], 1'b0} ^ (v[M-1] ? POLY : '0);
  endfunction

  function automatic logic [M-1:0] mul_step(input logic [M-1:0] acc,
                                            input logic [M-1:0] s,
                                            input logic         b);
    return xtime(acc) ^ (b ? s : '0);
  endfunction

  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] acc;
    acc = '0;
    for (int i = M - 1; i >= 0; i--) acc = mul_step(acc, a, b[i]);
    return acc;
  endfunction

  state_t       state_q, state_d;
  logic [M-1:0] s_q, s_d;
  logic [M-1:0] r_q, r_d;
  logic [3:0]   round_q, round_d;
  logic         zero_q, zero_d;
  logic [M-1:0] inv_q, inv_d;
  logic         zerr_q, zerr_d;

`ifdef GF13_INV_PARALLEL_MUL_EN
  logic [M-1:0] pp [0:M];

  assign pp[0] = '0;
  generate
    for (genvar gi = 0; gi < M; gi++) begin : g_pp
      assign pp[gi+1] = mul_step(pp[gi], s_q, r_q[M-1-gi]);
    end
  endgenerate
`else
  logic [M-1:0] acc_q, acc_d;
  logic [3:0]   bit_q, bit_d;
  logic [M-1:0] acc_step;

  assign acc_step = mul_step(acc_q, s_q, r_q[bit_q]);
`endif

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    r_d     = r_q;
    round_d = round_q;
    zero_d  = zero_q;
    inv_d   = inv_q;
    zerr_d  = zerr_q;
`ifndef GF13_INV_PARALLEL_MUL_EN
    acc_d   = acc_q;
    bit_d   = bit_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          s_d     = bus.a_in;
          r_d     = 13'h0001;
          round_d = '0;
          zero_d  = (bus.a_in == '0);
          state_d = SQR;
        end
      end
      SQR: begin
        s_d     = gf_mul(s_q, s_q);
        state_d = MUL;
`ifndef GF13_INV_PARALLEL_MUL_EN
        acc_d   = '0;
        bit_d   = 4'd12;
`endif
      end
      MUL: begin
`ifdef GF13_INV_PARALLEL_MUL_EN
        r_d = pp[M];
        if (round_q == 4'd11) begin
          state_d = DONE;
          inv_d   = pp[M];
          zerr_d  = zero_q;
        end else begin
          round_d = round_q + 4'd1;
          state_d = SQR;
        end
`else
        acc_d = acc_step;
        if (bit_q == 4'd0) begin
          r_d = acc_step;
          if (round_q == 4'd11) begin
            state_d = DONE;
            inv_d   = acc_step;
            zerr_d  = zero_q;
          end else begin
            round_d = round_q + 4'd1;
            state_d = SQR;
          end
        end else begin
          bit_d = bit_q - 4'd1;
        end
`endif
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      r_q     <= '0;
      round_q <= '0;
      zero_q  <= 1'b0;
      inv_q   <= '0;
      zerr_q  <= 1'b0;
`ifndef GF13_INV_PARALLEL_MUL_EN
      acc_q   <= '0;
      bit_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      r_q     <= r_d;
      round_q <= round_d;
      zero_q  <= zero_d;
      inv_q   <= inv_d;
      zerr_q  <= zerr_d;
`ifndef GF13_INV_PARALLEL_MUL_EN
      acc_q   <= acc_d;
      bit_q   <= bit_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == SQR) || (state_q == MUL);
  assign bus.inv_out   = inv_q;
  assign bus.zero_err  = zerr_q;

endmodule

// File: tb/tb_gf13_inverter.sv
// Scoreboard bench for gf13_inverter: reference inverse by exponentiation, checked on every result.
module tb_gf13_inverter;

`ifdef GF13_INV_PARALLEL_MUL_EN
  localparam int LAT    = 24;
  localparam int N_RAND = 1000;
`else
  localparam int LAT    = 168;
  localparam int N_RAND = 300;
`endif
  localparam int BOUND = LAT + 200;

  logic clk;
  logic rst;
  gf13_inv_if bus ();

  gf13_inverter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [12:0] a;
    logic [12:0] inv;
    logic        zerr;
    int          e0;
  } exp_t;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          exp_done = 0;
  logic [12:0] last_inv = '0;

  // Carry-less product followed by polynomial long division by x^13+x^4+x^3+x+1.
  function automatic logic [12:0] ref_mul(input logic [12:0] a, input logic [12:0] b);
    logic [31:0] p;
    p = 32'd0;
    for (int i = 0; i < 13; i++)
      if (b[i]) p = p ^ ({19'd0, a} << i);
    for (int i = 24; i >= 13; i--)
      if (p[i]) p = p ^ (32'h0000201B << (i - 13));
    return p[12:0];
  endfunction

  function automatic logic [12:0] ref_inv(input logic [12:0] a);
    logic [12:0] r, base;
    int e;
    r = 13'h0001; base = a; e = 8190;
    while (e > 0) begin
      if (e % 2 == 1) r = ref_mul(r, base);
      base = ref_mul(base, base);
      e = e / 2;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
  end

  // Monitor: results are popped and compared; accepted operands get their expectation pushed.
  initial begin
    logic ov_prev;
    exp_t e;
    ov_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ov_prev = 1'b0;
      end else begin
        if (bus.out_valid) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_out_valid", 32'd1, 32'd0);
          end else begin
            if (!ov_prev) chk("latency", cyc - sb_q[0].e0, LAT);
            if (bus.out_ready) begin
              e = sb_q.pop_front();
              chk($sformatf("inv_a%0h", e.a), bus.inv_out, e.inv);
              chk($sformatf("zerr_a%0h", e.a), bus.zero_err, e.zerr);
              if (e.a != 13'd0) chk($sformatf("prod_a%0h", e.a), ref_mul(e.a, bus.inv_out), 13'h0001);
              $display("[TB] result a=0x%04h inv=0x%04h zero_err=%0b", e.a, bus.inv_out, bus.zero_err);
              last_inv = bus.inv_out;
              done_cnt++;
            end
          end
        end
        ov_prev = bus.out_valid;
        if (bus.in_valid && bus.in_ready) begin
          e.a    = bus.a_in;
          e.inv  = ref_inv(bus.a_in);
          e.zerr = (bus.a_in == 13'd0);
          e.e0   = cyc + 1;
          sb_q.push_back(e);
        end
      end
    end
  end

  task automatic send(input logic [12:0] a);
    int n;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.a_in     = a;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a_in     = 13'($urandom);
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < target) chk("done_timeout", done_cnt, target);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_inv_out"}, bus.inv_out, 0);
    chk({tag, "_zero_err"}, bus.zero_err, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a_in      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Identity element.
    send(13'h0001); exp_done++;
    wait_done(exp_done);
    chk("one_val", last_inv, 13'h0001);

    // alpha, with busy/in_ready watched across the whole computation.
    send(13'h0002); exp_done++;
    n = 0;
    while (n < LAT + 5) begin
      @(negedge clk);
      if (bus.out_valid) break;
      chk("alpha_busy", bus.busy, 1);
      chk("alpha_in_ready", bus.in_ready, 0);
      n++;
    end
    wait_done(exp_done);
    chk("alpha_val", last_inv, 13'h100D);

    // Zero operand.
    send(13'h0000); exp_done++;
    wait_done(exp_done);
    chk("zero_val", last_inv, 13'h0000);

    // Backpressure: result must hold for 20 cycles.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(13'h1234); exp_done++;
    n = 0;
    while (!bus.out_valid && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 20; k++) begin
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_inv_out", bus.inv_out, ref_inv(13'h1234));
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_handoff_in_ready", bus.in_ready, 0);
    @(negedge clk);
    chk("bp_idle_in_ready", bus.in_ready, 1);
    chk("bp_idle_out_valid", bus.out_valid, 0);
    wait_done(exp_done);

    // Reset in the middle of a computation.
    send(13'h1ABC);
    repeat (49) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    send(13'h0002); exp_done++;
    wait_done(exp_done);
    chk("post_rst_alpha", last_inv, 13'h100D);

    // Random nonzero operands, back to back.
    for (int i = 0; i < N_RAND; i++) begin
      send(13'($urandom_range(1, 8191)));
      exp_done++;
    end
    wait_done(exp_done);
    chk("queue_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
